// File: rtl/lif_pkg.sv
// Shared types for the LIF neuron array: controller states and beat width.
package lif_pkg;

  localparam int BEAT_W = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    UPDATE  = 2'd1,
    LOAD    = 2'd2
  } state_t;

endpackage

// File: rtl/lif_neuron_core.sv
// One leaky integrate-and-fire neuron: popcount synapses, leak, saturate, fire.
// Optional refractory counter enabled by LIF_REFRACTORY_EN.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int INPUTS  = 64,
  parameter int U_W     = 10,
  parameter int REFRACT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic [INPUTS-1:0] w,
  input  logic [INPUTS-1:0] x,
  input  logic [2:0]        shift,
  input  logic [U_W-1:0]    threshold,
  output logic              spike,
  output logic [U_W-1:0]    u
);

  if (REFRACT < 0) begin : g_bad_refract
    $error("lif_neuron_core: REFRACT must be non-negative");
  end

  logic [U_W-1:0]    u_q, u_d;
  logic              spike_q, spike_d;
  logic              refr_active;
  logic [INPUTS-1:0] wx;
  logic [U_W:0]      dot;
  logic [U_W:0]      dot_eff;
  logic [U_W-1:0]    leak;
  logic [U_W:0]      v_wide;
  logic [U_W-1:0]    v;
  logic              fire;

`ifdef LIF_REFRACTORY_EN
  localparam int R_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [R_W-1:0] REFRACT_V = R_W'(REFRACT);
  logic [R_W-1:0] refr_q, refr_d;

  assign refr_active = (refr_q != '0);

  always_comb begin
    refr_d = refr_q;
    if (update) begin
      if (fire)
        refr_d = REFRACT_V;
      else if (refr_active)
        refr_d = refr_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) refr_q <= '0;
    else       refr_q <= refr_d;
  end
`else
  assign refr_active = 1'b0;
`endif

  always_comb begin
    wx  = w & x;
    dot = '0;
    for (int i = 0; i < INPUTS; i++)
      dot = dot + {{U_W{1'b0}}, wx[i]};
    dot_eff = refr_active ? '0 : dot;
    // Shift of zero means no leak, not "leak everything".
    leak   = (shift == 3'd0) ? '0 : (u_q >> shift);
    v_wide = {1'b0, u_q} - {1'b0, leak} + dot_eff;
    v      = v_wide[U_W] ? '1 : v_wide[U_W-1:0];
    fire   = !refr_active && (v >= threshold);

    u_d     = u_q;
    spike_d = spike_q;
    if (update) begin
      spike_d = fire;
      u_d     = fire ? (v - threshold) : v;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      u_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      u_q     <= u_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;
  assign u     = u_q;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons sharing one byte-streamed input vector; weights are
// streamed in LOAD. Refractory behaviour is selected with LIF_REFRACTORY_EN.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int INPUTS  = 64,
  parameter int NEURONS = 4,
  parameter int U_W     = 10,
  parameter int REFRACT = 2,
  localparam int SEL_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic               data_valid,
  input  logic [7:0]         data_in,
  output logic               data_ready,
  input  logic [2:0]         shift,
  input  logic [U_W-1:0]     threshold,
  output logic [NEURONS-1:0] spikes,
  output logic               step_done,
  input  logic [SEL_W-1:0]   u_sel,
  output logic [U_W-1:0]     u_out
);

  localparam int BEATS  = INPUTS / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int W_BITS = NEURONS * INPUTS;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((INPUTS % BEAT_W) != 0 || INPUTS < BEAT_W) begin : g_bad_inputs
    $error("lif_neuron_array: INPUTS must be a multiple of 8 and >= 8");
  end
  if (U_W < $clog2(INPUTS + 1)) begin : g_bad_uw
    $error("lif_neuron_array: U_W too narrow for INPUTS");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [INPUTS-1:0]  x_q, x_d;
  logic [W_BITS-1:0]  w_q, w_d;
  logic               step_done_q, step_done_d;
  logic [U_W-1:0]     u_vec [NEURONS];

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    x_d         = x_q;
    w_d         = w_q;
    step_done_d = 1'b0;
    case (state_q)
      COLLECT: begin
        // Switching to weight load drops any partially collected vector.
        if (load_en) begin
          state_d    = LOAD;
          beat_cnt_d = '0;
        end else if (data_valid) begin
          x_d = INPUTS'({x_q, data_in});
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = UPDATE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      UPDATE: begin
        state_d     = COLLECT;
        step_done_d = 1'b1;
      end
      LOAD: begin
        if (data_valid)
          w_d = W_BITS'({w_q, data_in});
        if (!load_en) begin
          state_d    = COLLECT;
          beat_cnt_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      beat_cnt_q  <= '0;
      x_q         <= '0;
      w_q         <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      x_q         <= x_d;
      w_q         <= w_d;
      step_done_q <= step_done_d;
    end
  end

  assign data_ready = (state_q != UPDATE);
  assign step_done  = step_done_q;

  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
    lif_neuron_core #(
      .INPUTS (INPUTS),
      .U_W    (U_W),
      .REFRACT(REFRACT)
    ) u_core (
      .clk      (clk),
      .reset    (reset),
      .update   (state_q == UPDATE),
      .w        (w_q[gi*INPUTS +: INPUTS]),
      .x        (x_q),
      .shift    (shift),
      .threshold(threshold),
      .spike    (spikes[gi]),
      .u        (u_vec[gi])
    );
  end

  always_comb begin
    u_out = '0;
    for (int k = 0; k < NEURONS; k++)
      if (int'(u_sel) == k) u_out = u_vec[k];
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array (INPUTS=16, NEURONS=2, U_W=8).
module tb_lif_neuron_array;

  localparam int INPUTS  = 16;
  localparam int NEURONS = 2;
  localparam int U_W     = 8;
  localparam int REFRACT = 2;
`ifdef LIF_REFRACTORY_EN
  localparam bit REFR_EN = 1'b1;
`else
  localparam bit REFR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sp;
    logic [7:0] u0;
    logic [7:0] u1;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_en;
  logic         data_valid;
  logic [7:0]   data_in;
  logic         data_ready;
  logic [2:0]   shift;
  logic [U_W-1:0] threshold;
  logic [NEURONS-1:0] spikes;
  logic         step_done;
  logic [0:0]   u_sel;
  logic [U_W-1:0] u_out;

  lif_neuron_array #(
    .INPUTS(INPUTS), .NEURONS(NEURONS), .U_W(U_W), .REFRACT(REFRACT)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .data_valid(data_valid),
    .data_in(data_in), .data_ready(data_ready), .shift(shift),
    .threshold(threshold), .spikes(spikes), .step_done(step_done),
    .u_sel(u_sel), .u_out(u_out)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  // Reference model state: plain integers
  int   u_m[NEURONS];
  int   refr_m[NEURONS];
  int   x_m;
  longint w_m;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(output exp_t e);
    int wk, dot, leak, v;
    e = '0;
    for (int k = 0; k < NEURONS; k++) begin
      wk   = int'((w_m >> (INPUTS * k)) & 64'hFFFF);
      dot  = (refr_m[k] > 0) ? 0 : $countones(wk & x_m);
      leak = (shift == 0) ? 0 : (u_m[k] >> shift);
      v    = u_m[k] - leak + dot;
      if (v > 255) v = 255;
      if (refr_m[k] == 0 && v >= int'(threshold)) begin
        e.sp[k]   = 1'b1;
        u_m[k]    = v - int'(threshold);
        refr_m[k] = REFR_EN ? REFRACT : 0;
      end else begin
        u_m[k] = v;
        if (refr_m[k] > 0) refr_m[k]--;
      end
    end
    e.u0 = u_m[0][7:0];
    e.u1 = u_m[1][7:0];
  endtask

  task automatic send_beat(input logic [7:0] b, input bit keep);
    bit ok;
    data_in    = b;
    data_valid = 1'b1;
    for (int t = 0; ; t++) begin
      if (t >= 50) begin
        $display("FAIL beat_accept: data_ready stuck at %0d, expected 1", data_ready);
        $fatal(1, "handshake timeout");
      end
      ok = data_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!keep) data_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] xv, input bit keep,
                          input bit use_const, input exp_t ce);
    exp_t e;
    send_beat(xv[15:8], 1'b1);
    send_beat(xv[7:0], keep);
    x_m = int'(xv);
    model_step(e);
    exp_q.push_back(use_const ? ce : e);
    $display("vec x=%04h shift=%0d th=%0d -> sp=%b u0=%0d u1=%0d",
             xv, shift, threshold, e.sp, e.u0, e.u1);
    if (!keep) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wload_begin();
    data_valid = 1'b0;
    load_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wbeat(input logic [7:0] b);
    send_beat(b, 1'b0);
    w_m = ((w_m << 8) | longint'(b)) & 64'hFFFF_FFFF;
  endtask

  task automatic wload_end();
    data_valid = 1'b0;
    load_en    = 1'b0;
    @(posedge clk);
    #1;
    $display("wload w=%08h", w_m);
  endtask

  // Stimulus
  initial begin
    exp_t ce;
    bit   hold;
    reset = 1'b1; load_en = 1'b0; data_valid = 1'b0; data_in = '0;
    shift = '0; threshold = '0;
    for (int k = 0; k < NEURONS; k++) begin u_m[k] = 0; refr_m[k] = 0; end
    x_m = 0; w_m = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    wload_begin();
    wbeat(8'hFF); wbeat(8'hFF); wbeat(8'h00); wbeat(8'h0F);
    wload_end();

    threshold = 8'd20; shift = 3'd0;
    ce = '{sp: 2'b00, u0: 8'd4, u1: 8'd16};
    send_vec(16'hFFFF, 1'b0, 1'b1, ce);
    ce = '{sp: 2'b10, u0: 8'd8, u1: 8'd12};
    send_vec(16'hFFFF, 1'b0, 1'b1, ce);

    shift = 3'd1; threshold = 8'd255;
    ce = '{sp: 2'b00, u0: 8'd8, u1: 8'd22};
    send_vec(16'hFFFF, 1'b0, !REFR_EN, ce);

    // Back-to-back vectors with data_valid held: drives u1 into saturation
    shift = 3'd0;
    for (int i = 0; i < 16; i++)
      send_vec(16'hFFFF, (i != 15), 1'b0, ce);

    threshold = 8'd0;
    send_vec(16'h1234, 1'b0, 1'b0, ce);
    send_vec(16'h0000, 1'b0, 1'b0, ce);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          send_beat(8'($urandom), 1'b0);
          x_m = ((x_m << 8) | int'(data_in)) & 16'hFFFF;
        end
        wload_begin();
        for (int b = 0; b < int'($urandom_range(1, 6)); b++)
          wbeat(8'($urandom));
        wload_end();
      end
      shift     = 3'($urandom_range(0, 7));
      threshold = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      hold      = 1'($urandom_range(0, 1));
      for (int j = 0; j < 3; j++)
        send_vec(16'($urandom), hold && (j != 2), 1'b0, ce);
    end
    stim_done = 1'b1;
  end

  // Monitor: pops the scoreboard whenever step_done pulses
  initial begin
    exp_t e;
    logic [1:0] last_sp;
    logic prev_ready;
    int   cyc;
    u_sel = 1'b0;
    last_sp = 2'b00;
    prev_ready = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (reset) @(negedge clk);
    chk("rst_spikes", int'(spikes), 0);
    chk("rst_ready", int'(data_ready), 1);
    chk("rst_step_done", int'(step_done), 0);
    u_sel = 1'b0; #1;
    chk("rst_u0", int'(u_out), 0);
    u_sel = 1'b1; #1;
    chk("rst_u1", int'(u_out), 0);
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        chk("watchdog_cycles", cyc, 20000);
        break;
      end
      if (!prev_ready)
        chk("ready_low_then_done", int'(step_done), 1);
      if (step_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_step_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("spikes", int'(spikes), int'(e.sp));
          chk("ready_after_update", int'(data_ready), 1);
          u_sel = 1'b0; #1;
          chk("u0", int'(u_out), int'(e.u0));
          u_sel = 1'b1; #1;
          chk("u1", int'(u_out), int'(e.u1));
          $display("step sp=%b u0=%0d u1=%0d", spikes, e.u0, e.u1);
          last_sp = e.sp;
        end
      end else begin
        chk("spikes_hold", int'(spikes), int'(last_sp));
      end
      prev_ready = data_ready;
      if (stim_done && exp_q.size() == 0) break;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter INPUTS, default 64, meaning synapse count per neuron; it must be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter NEURONS, default 4, meaning the number of neurons sharing one input vector.
REQ-003 SHALL have parameter U_W, default 10, meaning the unsigned membrane width; U_W must be at least clog2(INPUTS+1).
REQ-004 SHALL have parameter REFRACT, default 2, meaning refractory length in steps; it is used only with LIF_REFRACTORY_EN.
REQ-005 Ports SHALL be as follows, clock and reset first:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  1 = beats go to weights, 0 = beats go to inputs.
- data_valid  in  1  beat strobe.
- data_in  in  8  beat payload.
- data_ready  out  1  beat accepted when data_valid && data_ready.
- shift  in  3  leak shift; 0 = no leak.
- threshold  in  U_W  firing threshold.
- spikes  out  NEURONS  registered spike vector.
- step_done  out  1  one-cycle pulse after each update.
- u_sel  in  clog2(NEURONS)  membrane observe select.
- u_out  out  U_W  membrane of the selected neuron.

Function
REQ-006 FSM states SHALL be COLLECT, UPDATE and LOAD; after reset the state is COLLECT.
REQ-007 In COLLECT, each accepted beat SHALL shift x left by 8 bits (x <= {x[INPUTS-9:0], data_in}) and increment beat_cnt.
REQ-008 On the accepted beat that makes beat_cnt reach INPUTS/8, the FSM SHALL enter UPDATE next cycle and clear beat_cnt.
REQ-009 UPDATE SHALL last exactly one cycle with data_ready=0; data_valid in that cycle is ignored.
REQ-010 The FSM SHALL return to COLLECT after UPDATE, and step_done SHALL pulse in the cycle after UPDATE.
REQ-011 data_ready SHALL be 1 in COLLECT and LOAD.
REQ-012 In COLLECT with load_en=1, the FSM SHALL go to LOAD and clear beat_cnt; x is left unchanged.
REQ-013 In LOAD with load_en=0, the FSM SHALL go to COLLECT and clear beat_cnt.
REQ-014 In LOAD, each accepted beat SHALL shift w (NEURONS*INPUTS bits) left by 8 bits with data_in entering the LSBs.
REQ-015 Neuron k SHALL use w[k*INPUTS +: INPUTS] as its weights; there is no end-of-load condition, and extra beats keep shifting.
REQ-016 load_en rising during a partial input vector SHALL discard the partial count; no update occurs.
REQ-017 Per neuron in UPDATE: dot = popcount(w_k & x), in the range 0..INPUTS.
REQ-018 Per neuron in UPDATE: leak = (shift==0) ? 0 : (u >> shift); v = u - leak + dot, computed at U_W+1 bits and saturated to 2^U_W-1.
REQ-019 Per neuron in UPDATE: if v >= threshold then spikes[k] <= 1 and u <= v - threshold; otherwise spikes[k] <= 0 and u <= v.
REQ-020 threshold=0 SHALL make every neuron spike on every step, with u unchanged by the subtraction.
REQ-021 shift and threshold SHALL be sampled in the UPDATE cycle only.
REQ-022 spikes SHALL hold its value until the next UPDATE.
REQ-023 u_out SHALL be a combinational mux of the registered u[u_sel]; u_sel >= NEURONS returns 0.

Reset
REQ-024 Reset SHALL clear x, w, every u, spikes, step_done, beat_cnt and all refractory counters, and set the state to COLLECT; after reset data_ready=1.
REQ-025 Reset during UPDATE or LOAD SHALL abort the operation; no partial update is committed.

Configuration
REQ-026 With LIF_REFRACTORY_EN defined, a neuron that spikes SHALL load its counter with REFRACT.
REQ-027 With LIF_REFRACTORY_EN defined, while a neuron's counter is nonzero, UPDATE uses dot=0, cannot spike, and decrements the counter.
REQ-028 Without LIF_REFRACTORY_EN, there SHALL be no counters and the behaviour is exactly REQ-017..REQ-019.

Structure
REQ-029 Package lif_pkg SHALL hold the FSM state enum (COLLECT, UPDATE, LOAD) and the BEAT_W=8 constant.
REQ-030 Sub-module lif_neuron_core SHALL hold one neuron's popcount, leak, saturation, threshold and refractory logic; it is instantiated NEURONS times via generate.

Verification (INPUTS=16, NEURONS=2, U_W=8)
REQ-031 Reset: after reset, spikes=0, u_out=0, data_ready=1, step_done=0.
REQ-032 Weight load: load_en=1, beats FF,FF,00,0F -> neuron1 w=0xFFFF, neuron0 w=0x000F; no step_done pulse.
REQ-033 Accumulate: load_en=0, threshold=20, shift=0, two vectors of FF,FF -> step 1: u1=16, u0=4, spikes=00; step 2: spikes=10, u1=12, u0=8.
REQ-034 Leak and saturation: shift=1 from u1=12 with dot=16 -> u1=22; threshold=255 with repeated vectors -> u1 clamps at 255, then spikes and u1=0.
REQ-035 Handshake: data_valid held high across a full vector -> data_ready=0 exactly in UPDATE; no beat lost or duplicated.
REQ-036 Refractory (LIF_REFRACTORY_EN, REFRACT=2): after a spike, the next 2 steps give spikes[k]=0 and u unchanged apart from leak.
